// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter sequencer: op encoding,
// command priority order and a constant clog2 for sizing the stack pointer.
package pc_pkg;

  typedef enum logic [2:0] {
    OP_HOLD   = 3'd0,
    OP_INC    = 3'd1,
    OP_BRANCH = 3'd2,
    OP_LOAD   = 3'd3,
    OP_CALL   = 3'd4,
    OP_RET    = 3'd5
  } pc_op_e;

  localparam int NUM_CMDS = 5;

  // Lowest priority in the least significant slot; later slots override earlier ones.
  localparam logic [3*NUM_CMDS-1:0] OP_PRIORITY = {OP_RET, OP_CALL, OP_LOAD, OP_BRANCH, OP_INC};

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  // req is indexed by pc_op_e value; bit 0 (OP_HOLD) is ignored.
  function automatic pc_op_e pc_select_op(input logic [5:0] req);
    pc_op_e sel;
    pc_op_e cand;
    sel = OP_HOLD;
    for (int i = 0; i < NUM_CMDS; i++) begin
      cand = pc_op_e'(OP_PRIORITY[3*i +: 3]);
      if (req[cand]) sel = cand;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pc_return_stack.sv
// Register-array LIFO holding return addresses for call/ret.
// Push and pop are ignored when the stack is full or empty respectively.
module pc_return_stack
  import pc_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          push,
  input  logic                          pop,
  input  logic [ADDR_W-1:0]             push_data,
  output logic [ADDR_W-1:0]             top,
  output logic [clog2(STACK_DEPTH):0]   sp,
  output logic                          full,
  output logic                          empty
);

  localparam int PTR_W = clog2(STACK_DEPTH);
  localparam int SP_W  = PTR_W + 1;

  logic [ADDR_W-1:0] mem [STACK_DEPTH];
  logic [SP_W-1:0]   sp_m1;

  assign full  = (sp == SP_W'(STACK_DEPTH));
  assign empty = (sp == '0);
  assign sp_m1 = sp - SP_W'(1);
  assign top   = mem[sp_m1[PTR_W-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + SP_W'(1);
    end else if (pop && !empty) begin
      sp <= sp_m1;
    end
  end

  // NOTE: the storage array carries no reset; contents are meaningless
  // while sp says they are unoccupied, so resetting them only costs logic.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[sp[PTR_W-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with stall, relative branch and call/return.
// Optional build macro PC_STACK_TRAP_EN redirects stack over/underflow to TRAP_ADDR.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                       ADDR_W      = 8,
  parameter int                       STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0]        RESET_ADDR  = '0,
  parameter logic [ADDR_W-1:0]        TRAP_ADDR   = '1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        stall,
  input  logic                        inc,
  input  logic                        load,
  input  logic                        branch,
  input  logic                        call,
  input  logic                        ret,
  input  logic [ADDR_W-1:0]           target,
  input  logic [ADDR_W-1:0]           offset,
  input  logic                        clr_err,
  output logic [ADDR_W-1:0]           addr_out,
  output logic [clog2(STACK_DEPTH):0] sp,
  output logic                        stack_full,
  output logic                        stack_empty,
  output logic                        ovf_err,
  output logic                        unf_err
);

  logic [5:0]        req;
  pc_op_e            op;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] stack_top;
  logic              push;
  logic              pop;
  logic              ovf_set;
  logic              unf_set;

  assign req      = {ret, call, load, branch, inc, 1'b0};
  assign op       = pc_select_op(req);
  assign pc_plus1 = addr_out + ADDR_W'(1);

`ifdef PC_STACK_TRAP_EN
  localparam logic [ADDR_W-1:0] ERR_ADDR_SEL = TRAP_ADDR;
`else
  logic unused_trap_addr;
  assign unused_trap_addr = ^TRAP_ADDR;
`endif

  // NOTE: every output of this block gets a default first so no path
  // through the case leaves a signal unassigned and infers a latch.
  always_comb begin
    pc_next = addr_out;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (!stall) begin
      case (op)
        OP_INC:    pc_next = pc_plus1;
        OP_LOAD:   pc_next = target;
        OP_BRANCH: pc_next = addr_out + offset;
        OP_CALL: begin
          if (stack_full) begin
            ovf_set = 1'b1;
`ifdef PC_STACK_TRAP_EN
            pc_next = ERR_ADDR_SEL;
`else
            pc_next = pc_plus1;
`endif
          end else begin
            push    = 1'b1;
            pc_next = target;
          end
        end
        OP_RET: begin
          if (stack_empty) begin
            unf_set = 1'b1;
`ifdef PC_STACK_TRAP_EN
            pc_next = ERR_ADDR_SEL;
`else
            pc_next = pc_plus1;
`endif
          end else begin
            pop     = 1'b1;
            pc_next = stack_top;
          end
        end
        default:   pc_next = addr_out;
      endcase
    end
  end

  // A new error in the same cycle as clr_err wins over the clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_out <= RESET_ADDR;
      ovf_err  <= 1'b0;
      unf_err  <= 1'b0;
    end else begin
      addr_out <= pc_next;
      ovf_err  <= ovf_set | (ovf_err & ~clr_err);
      unf_err  <= unf_set | (unf_err & ~clr_err);
    end
  end

  pc_return_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .push_data (pc_plus1),
    .top       (stack_top),
    .sp        (sp),
    .full      (stack_full),
    .empty     (stack_empty)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (default build, ADDR_W=8, depth 4).
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       stall, inc, load, branch, call, ret, clr_err;
  logic [7:0] target, offset;
  logic [7:0] addr_out;
  logic [2:0] sp;
  logic       stack_full, stack_empty, ovf_err, unf_err;

  int compared   = 0;
  int mismatched = 0;

  pc_sequencer #(
    .ADDR_W      (8),
    .STACK_DEPTH (4),
    .RESET_ADDR  (8'h00),
    .TRAP_ADDR   (8'hFF)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .stall       (stall),
    .inc         (inc),
    .load        (load),
    .branch      (branch),
    .call        (call),
    .ret         (ret),
    .target      (target),
    .offset      (offset),
    .clr_err     (clr_err),
    .addr_out    (addr_out),
    .sp          (sp),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .ovf_err     (ovf_err),
    .unf_err     (unf_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cmds();
    stall = 0; inc = 0; load = 0; branch = 0; call = 0; ret = 0; clr_err = 0;
    target = 8'h00; offset = 8'h00;
  endtask

  task automatic test_reset();
    idle_cmds();
    reset_n = 0;
    inc = 1;
    tick();
    tick();
    compared++;
    if ({addr_out, sp, stack_empty, stack_full, ovf_err, unf_err} !== {8'h00, 3'd0, 4'b1000}) begin
      mismatched++;
      $display("FAIL reset_hold: pc=%h sp=%0d e=%b f=%b ovf=%b unf=%b, required pc=00 sp=0 e=1 f=0 ovf=0 unf=0",
               addr_out, sp, stack_empty, stack_full, ovf_err, unf_err);
    end
    inc = 0;
    reset_n = 1;
    tick();
    compared++;
    if ({addr_out, sp, stack_empty} !== {8'h00, 3'd0, 1'b1}) begin
      mismatched++;
      $display("FAIL reset_release: pc=%h sp=%0d e=%b, required pc=00 sp=0 e=1", addr_out, sp, stack_empty);
    end
  endtask

  task automatic test_inc_wrap();
    logic [7:0] exp;
    idle_cmds();
    inc = 1;
    for (int i = 1; i <= 257; i++) begin
      tick();
      exp = 8'(i);
      compared++;
      if (addr_out !== exp) begin
        mismatched++;
        $display("FAIL inc_step_%0d: pc=%h required %h", i, addr_out, exp);
      end
    end
    idle_cmds();
  endtask

  task automatic test_branch_load();
    logic [7:0] exp_pc [6];
    exp_pc = '{8'h10, 8'h00, 8'hFE, 8'h03, 8'h03, 8'h40};
    for (int i = 0; i < 6; i++) begin
      idle_cmds();
      case (i)
        0: begin load = 1; target = 8'h10; end
        1: begin branch = 1; offset = 8'hF0; end
        2: begin load = 1; target = 8'hFE; end
        3: begin branch = 1; offset = 8'h05; end
        4: begin branch = 1; offset = 8'h00; end
        default: begin load = 1; inc = 1; target = 8'h40; end
      endcase
      tick();
      compared++;
      if (addr_out !== exp_pc[i]) begin
        mismatched++;
        $display("FAIL branch_load_%0d: pc=%h required %h", i, addr_out, exp_pc[i]);
      end
    end
    idle_cmds();
    load = 1; branch = 1; target = 8'h22; offset = 8'h01;
    tick();
    compared++;
    if (addr_out !== 8'h22) begin
      mismatched++;
      $display("FAIL load_over_branch: pc=%h required 22", addr_out);
    end
    idle_cmds();
  endtask

  task automatic test_call_ret();
    logic [7:0] call_tgt [4];
    logic [7:0] ret_pc   [4];
    call_tgt = '{8'h20, 8'h30, 8'h40, 8'h50};
    ret_pc   = '{8'h41, 8'h31, 8'h21, 8'h01};
    idle_cmds();
    load = 1; target = 8'h00;
    tick();
    for (int i = 0; i < 4; i++) begin
      idle_cmds();
      call = 1; target = call_tgt[i];
      tick();
      compared++;
      if ({addr_out, sp, stack_full} !== {call_tgt[i], 3'(i + 1), (i == 3)}) begin
        mismatched++;
        $display("FAIL call_%0d: pc=%h sp=%0d full=%b, required pc=%h sp=%0d full=%b",
                 i, addr_out, sp, stack_full, call_tgt[i], i + 1, (i == 3));
      end
    end
    call = 1; target = 8'h60;
    tick();
    compared++;
    if ({addr_out, sp, ovf_err, stack_full} !== {8'h51, 3'd4, 1'b1, 1'b1}) begin
      mismatched++;
      $display("FAIL call_overflow: pc=%h sp=%0d ovf=%b full=%b, required pc=51 sp=4 ovf=1 full=1",
               addr_out, sp, ovf_err, stack_full);
    end
    for (int i = 0; i < 4; i++) begin
      idle_cmds();
      ret = 1;
      if (i == 0) begin call = 1; target = 8'h99; end
      tick();
      compared++;
      if ({addr_out, sp, stack_empty} !== {ret_pc[i], 3'(3 - i), (i == 3)}) begin
        mismatched++;
        $display("FAIL ret_%0d: pc=%h sp=%0d empty=%b, required pc=%h sp=%0d empty=%b",
                 i, addr_out, sp, stack_empty, ret_pc[i], 3 - i, (i == 3));
      end
    end
    compared++;
    if (ovf_err !== 1'b1) begin
      mismatched++;
      $display("FAIL ovf_sticky: ovf=%b required 1", ovf_err);
    end
    idle_cmds();
    clr_err = 1;
    tick();
    compared++;
    if ({ovf_err, addr_out} !== {1'b0, 8'h01}) begin
      mismatched++;
      $display("FAIL ovf_clear: ovf=%b pc=%h, required ovf=0 pc=01", ovf_err, addr_out);
    end
    idle_cmds();
  endtask

  task automatic test_underflow_clr();
    idle_cmds();
    load = 1; target = 8'h07;
    tick();
    idle_cmds();
    ret = 1;
    tick();
    compared++;
    if ({addr_out, sp, unf_err} !== {8'h08, 3'd0, 1'b1}) begin
      mismatched++;
      $display("FAIL ret_underflow: pc=%h sp=%0d unf=%b, required pc=08 sp=0 unf=1", addr_out, sp, unf_err);
    end
    idle_cmds();
    tick();
    compared++;
    if ({addr_out, unf_err} !== {8'h08, 1'b1}) begin
      mismatched++;
      $display("FAIL unf_sticky: pc=%h unf=%b, required pc=08 unf=1", addr_out, unf_err);
    end
    clr_err = 1;
    tick();
    compared++;
    if ({addr_out, unf_err} !== {8'h08, 1'b0}) begin
      mismatched++;
      $display("FAIL unf_clear: pc=%h unf=%b, required pc=08 unf=0", addr_out, unf_err);
    end
    idle_cmds();
    ret = 1;
    tick();
    idle_cmds();
    ret = 1; clr_err = 1;
    tick();
    compared++;
    if ({addr_out, unf_err} !== {8'h0A, 1'b1}) begin
      mismatched++;
      $display("FAIL set_beats_clear: pc=%h unf=%b, required pc=0a unf=1", addr_out, unf_err);
    end
    idle_cmds();
  endtask

  task automatic test_stall();
    idle_cmds();
    load = 1; target = 8'h05;
    tick();
    for (int i = 0; i < 3; i++) begin
      idle_cmds();
      stall = 1; call = 1; target = 8'h33;
      if (i == 0) clr_err = 1;
      else ret = 1;
      tick();
      compared++;
      if ({addr_out, sp, unf_err} !== {8'h05, 3'd0, 1'b0}) begin
        mismatched++;
        $display("FAIL stall_%0d: pc=%h sp=%0d unf=%b, required pc=05 sp=0 unf=0", i, addr_out, sp, unf_err);
      end
    end
    idle_cmds();
    call = 1; target = 8'h33;
    tick();
    compared++;
    if ({addr_out, sp} !== {8'h33, 3'd1}) begin
      mismatched++;
      $display("FAIL stall_release: pc=%h sp=%0d, required pc=33 sp=1", addr_out, sp);
    end
    idle_cmds();
  endtask

  task automatic test_reset_midcall();
    idle_cmds();
    call = 1; target = 8'h44;
    tick();
    compared++;
    if ({addr_out, sp} !== {8'h44, 3'd2}) begin
      mismatched++;
      $display("FAIL pre_reset_call: pc=%h sp=%0d, required pc=44 sp=2", addr_out, sp);
    end
    call = 1; target = 8'h77; reset_n = 0;
    tick();
    compared++;
    if ({addr_out, sp, stack_empty, stack_full, ovf_err, unf_err} !== {8'h00, 3'd0, 4'b1000}) begin
      mismatched++;
      $display("FAIL reset_midcall: pc=%h sp=%0d e=%b f=%b ovf=%b unf=%b, required pc=00 sp=0 e=1 f=0 ovf=0 unf=0",
               addr_out, sp, stack_empty, stack_full, ovf_err, unf_err);
    end
    idle_cmds();
    reset_n = 1;
    tick();
  endtask

  initial begin
    reset_n = 0;
    idle_cmds();
    test_reset();
    test_inc_wrap();
    test_branch_load();
    test_call_ret();
    test_underflow_clr();
    test_stall();
    test_reset_midcall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
